// File: rtl/servo_positioner.sv
// Frame-synchronous PWM servo positioner: moves between discrete index positions
// by driving whole PWM frames. Optional macro SERVO_HOLD_PULSE_EN adds a neutral hold pulse when not moving.
module servo_positioner #(
  parameter int NUM_POS          = 3,
  parameter int POS_W            = 2,
  parameter int FRAME_TICKS      = 1000000,
  parameter int PULSE_ACW_TICKS  = 300000,
  parameter int PULSE_CW_TICKS   = 100000,
  parameter int PULSE_STOP_TICKS = 75000,
  parameter int FRAMES_PER_STEP  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [POS_W-1:0] req_pos,
  output logic             req_ready,
  output logic             pwm,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] cur_pos
);

  localparam int CNT_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int BUD_MAX = (NUM_POS - 1) * FRAMES_PER_STEP;
  localparam int BUD_W   = (BUD_MAX > 1) ? $clog2(BUD_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [POS_W:0]   NUM_POS_L = (POS_W + 1)'(NUM_POS);
  localparam logic [31:0]      ACW_L     = 32'(PULSE_ACW_TICKS);
  localparam logic [31:0]      CW_L      = 32'(PULSE_CW_TICKS);
`ifdef SERVO_HOLD_PULSE_EN
  localparam logic [31:0]      STOP_L    = 32'(PULSE_STOP_TICKS);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MOVE, S_DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [BUD_W-1:0]   budget;
  logic [POS_W-1:0]   target;
  logic               dir_acw;
  logic               wrap, in_range, load, last_frame, pwm_next;
  logic [POS_W-1:0]   diff;
  logic [31:0]        cnt_ext;

  assign wrap       = (cnt == CNT_LAST);
  assign cnt_next   = wrap ? '0 : cnt + 1'b1;
  assign cnt_ext    = 32'(cnt_next);
  assign in_range   = ({1'b0, req_pos} < NUM_POS_L);
  assign diff       = (req_pos > cur_pos) ? (req_pos - cur_pos) : (cur_pos - req_pos);
  assign last_frame = (budget <= BUD_W'(1));

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        // Out-of-range requests are consumed by the handshake but otherwise dropped.
        if (req_valid && in_range) begin
          if (req_pos == cur_pos) begin
            state_next = S_DONE;
          end else begin
            state_next = S_ARMED;
            load       = 1'b1;
          end
        end
      end
      S_ARMED: if (wrap) state_next = S_MOVE;
      S_MOVE:  if (wrap && last_frame) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // pwm is registered against the next counter value so it lines up with cnt.
  always_comb begin
    pwm_next = 1'b0;
    if (state_next == S_MOVE) begin
      pwm_next = (cnt_ext < (dir_acw ? ACW_L : CW_L));
    end else begin
`ifdef SERVO_HOLD_PULSE_EN
      pwm_next = (cnt_ext < STOP_L);
`else
      pwm_next = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pwm     <= 1'b0;
      budget  <= '0;
      target  <= '0;
      dir_acw <= 1'b0;
      cur_pos <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pwm   <= pwm_next;
      if (load) begin
        target  <= req_pos;
        dir_acw <= (req_pos > cur_pos);
        budget  <= BUD_W'(32'(diff) * 32'(FRAMES_PER_STEP));
      end else if (state == S_MOVE && wrap) begin
        budget <= budget - 1'b1;
        if (last_frame) cur_pos <= target;
      end
    end
  end

endmodule

// File: tb/tb_servo_positioner.sv
// Directed self-checking bench for servo_positioner; a second instance with
// NUM_POS=3 covers the out-of-range request case.
module tb_servo_positioner;

  localparam int FT = 100;
`ifdef SERVO_HOLD_PULSE_EN
  localparam int IDLEP = 15;
`else
  localparam int IDLEP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_pos = '0;
  logic       req_ready, pwm, busy, done;
  logic [1:0] cur_pos;

  logic       req_valid3 = 1'b0;
  logic [1:0] req_pos3 = '0;
  logic       req_ready3, pwm3, busy3, done3;
  logic [1:0] cur_pos3;

  int n_tests = 0;
  int n_fail  = 0;
  int tcnt    = 0;

  always #5 clk = ~clk;

  servo_positioner #(
    .NUM_POS(4), .POS_W(2), .FRAME_TICKS(100), .PULSE_ACW_TICKS(30),
    .PULSE_CW_TICKS(10), .PULSE_STOP_TICKS(15), .FRAMES_PER_STEP(2)
  ) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pos(req_pos),
    .req_ready(req_ready), .pwm(pwm), .busy(busy), .done(done), .cur_pos(cur_pos)
  );

  servo_positioner #(
    .NUM_POS(3), .POS_W(2), .FRAME_TICKS(100), .PULSE_ACW_TICKS(30),
    .PULSE_CW_TICKS(10), .PULSE_STOP_TICKS(15), .FRAMES_PER_STEP(2)
  ) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_pos(req_pos3),
    .req_ready(req_ready3), .pwm(pwm3), .busy(busy3), .done(done3), .cur_pos(cur_pos3)
  );

  // One clock; tcnt tracks the expected frame counter value after the edge.
  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) tcnt = 0;
    else   tcnt = (tcnt + 1) % FT;
  endtask

  // Runs n cycles, tallying pwm cycles that disagree with (tcnt < pulse).
  task automatic collect(input int n, input int pulse, output int mism,
                         output int highs, output int dones);
    mism = 0; highs = 0; dones = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (pwm !== ((tcnt < pulse) ? 1'b1 : 1'b0)) mism++;
      if (pwm === 1'b1) highs++;
      if (done === 1'b1) dones++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    n_tests++; if (cur_pos !== 2'd0) begin n_fail++; $display("FAIL reset_cur_pos: got %0d expected 0", cur_pos); end
    rst = 1'b0;
  endtask

  task automatic test_move_acw();
    int mism, highs, dones;
    for (int i = 0; i < FT && tcnt != 40; i++) step();
    req_valid = 1'b1; req_pos = 2'd3;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL acw_ready: got %b expected 1", req_ready); end
    step();
    req_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL acw_armed: busy %b ready %b expected 1 0", busy, req_ready); end
    n_tests++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL acw_armed_pwm: got %b expected 0", pwm); end
    collect(58, IDLEP, mism, highs, dones);
    n_tests++; if (mism != 0) begin n_fail++; $display("FAIL acw_armed_shape: got %0d bad cycles expected 0", mism); end
    collect(600, 30, mism, highs, dones);
    n_tests++; if (mism != 0) begin n_fail++; $display("FAIL acw_pwm_shape: got %0d bad cycles expected 0", mism); end
    n_tests++; if (highs != 180) begin n_fail++; $display("FAIL acw_pwm_highs: got %0d expected 180", highs); end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL acw_early_done: got %0d expected 0", dones); end
    step();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL acw_done: got %b expected 1", done); end
    n_tests++; if (cur_pos !== 2'd3) begin n_fail++; $display("FAIL acw_cur_pos: got %0d expected 3", cur_pos); end
    n_tests++; if (pwm !== ((IDLEP > 0) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL acw_done_pwm: got %b expected %b", pwm, IDLEP > 0); end
    step();
    n_tests++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL acw_after: done %b ready %b expected 0 1", done, req_ready); end
  endtask

  task automatic test_move_cw();
    int mism, highs, dones;
    req_valid = 1'b1; req_pos = 2'd1;
    step();
    req_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cw_armed: got %b expected 1", busy); end
    collect(97, IDLEP, mism, highs, dones);
    n_tests++; if (mism != 0) begin n_fail++; $display("FAIL cw_armed_shape: got %0d bad cycles expected 0", mism); end
    collect(400, 10, mism, highs, dones);
    n_tests++; if (mism != 0 || highs != 40) begin n_fail++; $display("FAIL cw_pwm: got %0d bad %0d highs expected 0 40", mism, highs); end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL cw_early_done: got %0d expected 0", dones); end
    step();
    n_tests++; if (done !== 1'b1 || cur_pos !== 2'd1) begin n_fail++; $display("FAIL cw_done: done %b pos %0d expected 1 1", done, cur_pos); end
    step();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL cw_single_done: got %b expected 0", done); end
  endtask

  task automatic test_same_pos();
    req_valid = 1'b1; req_pos = 2'd1;
    step();
    req_valid = 1'b0;
    n_tests++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL same_done: done %b busy %b expected 1 1", done, busy); end
    n_tests++; if (pwm !== ((tcnt < IDLEP) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL same_pwm: got %b expected %b", pwm, tcnt < IDLEP); end
    step();
    n_tests++; if (done !== 1'b0 || req_ready !== 1'b1 || cur_pos !== 2'd1) begin n_fail++; $display("FAIL same_after: done %b ready %b pos %0d expected 0 1 1", done, req_ready, cur_pos); end
  endtask

  task automatic test_out_of_range();
    int dones;
    dones = 0;
    req_valid3 = 1'b1; req_pos3 = 2'd3;
    n_tests++; if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL oor_ready: got %b expected 1", req_ready3); end
    step();
    req_valid3 = 1'b0;
    n_tests++; if (busy3 !== 1'b0 || req_ready3 !== 1'b1) begin n_fail++; $display("FAIL oor_state: busy %b ready %b expected 0 1", busy3, req_ready3); end
    for (int i = 0; i < 5; i++) begin step(); if (done3 === 1'b1) dones++; end
    n_tests++; if (dones != 0 || cur_pos3 !== 2'd0) begin n_fail++; $display("FAIL oor_ignored: dones %0d pos %0d expected 0 0", dones, cur_pos3); end
    req_valid3 = 1'b1; req_pos3 = 2'd2;
    step();
    req_valid3 = 1'b0;
    n_tests++; if (busy3 !== 1'b1) begin n_fail++; $display("FAIL oor_valid_taken: got %b expected 1", busy3); end
  endtask

  task automatic test_reset_mid_move();
    int dones;
    dones = 0;
    req_valid = 1'b1; req_pos = 2'd3;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < FT && tcnt != 99; i++) step();
    step();
    repeat (120) step();
    n_tests++; if (pwm !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_drive: pwm %b busy %b expected 1 1", pwm, busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (pwm !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_reset: pwm %b busy %b done %b expected 0 0 0", pwm, busy, done); end
    n_tests++; if (cur_pos !== 2'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pos: pos %0d ready %b expected 0 1", cur_pos, req_ready); end
    for (int i = 0; i < 150; i++) begin step(); if (done === 1'b1) dones++; end
    n_tests++; if (dones != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: dones %0d busy %b expected 0 0", dones, busy); end
  endtask

  task automatic test_back_to_back();
    int highs, cyc, seen;
    highs = 0; cyc = 0; seen = 0;
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 1'b1; req_pos = 2'd2;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (done === 1'b1) begin cyc = i; seen = 1; break; end
      if (pwm === 1'b1) highs++;
      req_pos = 2'(i % 4);
    end
    n_tests++; if (seen != 1 || cyc != 500) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected 500", cyc); end
    n_tests++; if (highs != 120 + ((IDLEP > 0) ? 14 : 0)) begin n_fail++; $display("FAIL b2b_highs: got %0d expected %0d", highs, 120 + ((IDLEP > 0) ? 14 : 0)); end
    n_tests++; if (cur_pos !== 2'd2) begin n_fail++; $display("FAIL b2b_cur_pos: got %0d expected 2", cur_pos); end
    req_pos = 2'd0;
    step();
    n_tests++; if (req_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: ready %b done %b expected 1 0", req_ready, done); end
    step();
    req_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_next_taken: got %b expected 1", busy); end
  endtask

  task automatic test_idle_pwm();
    int mism, highs, dones;
    rst = 1'b1; step(); rst = 1'b0;
    collect(200, IDLEP, mism, highs, dones);
    n_tests++; if (mism != 0) begin n_fail++; $display("FAIL idle_pwm_shape: got %0d bad cycles expected 0", mism); end
    n_tests++; if (highs != ((IDLEP > 0) ? 30 : 0)) begin n_fail++; $display("FAIL idle_pwm_highs: got %0d expected %0d", highs, (IDLEP > 0) ? 30 : 0); end
  endtask

  initial begin
    test_reset();
    test_move_acw();
    test_move_cw();
    test_same_pos();
    test_out_of_range();
    test_reset_mid_move();
    test_back_to_back();
    test_idle_pwm();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
